// File: rtl/sram_port_pkg.sv
// Shared types and helpers for the fabric-to-SRAM sub-word port controller.
// Lane helpers work per bit index so they stay independent of the word width.
package sram_port_pkg;

  typedef enum logic [2:0] {
    CONF_1B  = 3'd0,
    CONF_2B  = 3'd1,
    CONF_4B  = 3'd2,
    CONF_8B  = 3'd3,
    CONF_16B = 3'd4,
    CONF_32B = 3'd5
  } conf_e;

  localparam int LANE_W = 8;

  typedef struct packed {
    logic              valid;
    logic [2:0]        w;
    logic [LANE_W-1:0] lane;
  } rd_tag_t;

  function automatic logic [2:0] conf_clamp(input logic [2:0] conf, input int sub_w);
    return (int'(conf) > sub_w) ? 3'(sub_w) : conf;
  endfunction

  function automatic logic [LANE_W-1:0] lane_align(input logic [LANE_W-1:0] sub, input logic [2:0] w);
    return (sub >> w) << w;
  endfunction

  // Bit idx lies inside the 2^w-wide lane starting at bit lane.
  function automatic logic lane_bit(input int w, input int lane, input int idx);
    return (idx >= lane) && ((idx - lane) < (1 << w));
  endfunction

  // Bit idx is the base of one replicated copy of a 2^w-wide value.
  function automatic logic lane_start(input int w, input int idx);
    return (idx % (1 << w)) == 0;
  endfunction

endpackage

// File: rtl/sram_lane_shifter.sv
// Combinational lane logic: write mask / replicated write data for the issuing
// request, and right-justified extraction of the lane carried by a returning read.
module sram_lane_shifter
  import sram_port_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_wr_w,
  input  logic [LANE_W-1:0] i_wr_lane,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_rd_w,
  input  logic [LANE_W-1:0] i_rd_lane,
  input  logic [DATA_W-1:0] i_sram_dout,
  output logic [DATA_W-1:0] o_wmask,
  output logic [DATA_W-1:0] o_din,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_wlow;
  logic [DATA_W-1:0] w_rsh;

  always_comb begin
    w_wlow  = '0;
    o_wmask = '0;
    o_din   = '0;
    o_rdata = '0;
    w_rsh   = i_sram_dout >> i_rd_lane;
    for (int i = 0; i < DATA_W; i++) begin
      w_wlow[i]  = i_wdata[i] & lane_bit(int'(i_wr_w), 0, i);
      o_wmask[i] = lane_bit(int'(i_wr_w), int'(i_wr_lane), i);
      o_rdata[i] = w_rsh[i] & lane_bit(int'(i_rd_w), 0, i);
    end
    // Copy the write value into every lane so din is correct whatever lane is masked in.
    for (int i = 0; i < DATA_W; i++) begin
      if (lane_start(int'(i_wr_w), i)) o_din = o_din | (w_wlow << i);
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Fabric-to-SRAM port controller: issue registers, read tag pipe, credit-guarded
// response FIFO. Define SRAM_PORT_CTRL_FWD_EN to bypass the FIFO when it is empty.
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  BASE_W    = 9,
  parameter int  SRAM_LAT  = 1,
  parameter int  RSP_DEPTH = 4,
  localparam int SUB_W     = $clog2(DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [BASE_W+SUB_W-1:0] req_addr,
  input  logic [2:0]              req_conf,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [BASE_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_wmask,
  output logic [DATA_W-1:0]       sram_din,
  input  logic [DATA_W-1:0]       sram_dout
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [2:0]          w_req_w;
  logic [LANE_W-1:0]   w_req_lane;
  logic [DATA_W-1:0]   w_wmask, w_din, w_ext_rdata;
  logic                w_acc, w_rd_acc, w_fifo_ne, w_bypass, w_push, w_pop_fifo, w_rsp_hs;
  rd_tag_t             w_new_tag, w_exit;
  rd_tag_t [SRAM_LAT:0] r_tag;
  logic [DATA_W-1:0]   r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_fcnt, r_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_req_w    = conf_clamp(req_conf, SUB_W);
  assign w_req_lane = lane_align(LANE_W'(req_addr[BASE_W +: SUB_W]), w_req_w);
  assign req_ready  = r_cnt < CNT_W'(RSP_DEPTH);
  assign w_acc      = req_valid && req_ready;
  assign w_rd_acc   = w_acc && !req_we;
  assign w_new_tag  = '{valid: w_rd_acc, w: w_req_w, lane: w_req_lane};
  // r_tag[0] lines up with the csb-low cycle; the last stage with valid sram_dout.
  assign w_exit     = r_tag[SRAM_LAT];

  sram_lane_shifter #(.DATA_W(DATA_W)) u_shifter (
    .i_wr_w      (w_req_w),
    .i_wr_lane   (w_req_lane),
    .i_wdata     (req_wdata),
    .i_rd_w      (w_exit.w),
    .i_rd_lane   (w_exit.lane),
    .i_sram_dout (sram_dout),
    .o_wmask     (w_wmask),
    .o_din       (w_din),
    .o_rdata     (w_ext_rdata)
  );

  assign w_fifo_ne = r_fcnt != '0;
`ifdef SRAM_PORT_CTRL_FWD_EN
  assign w_bypass  = w_exit.valid && !w_fifo_ne && rsp_ready;
  assign rsp_valid = w_fifo_ne || w_bypass;
  assign rsp_rdata = w_fifo_ne ? r_fifo[r_rd_ptr] : (w_bypass ? w_ext_rdata : '0);
`else
  assign w_bypass  = 1'b0;
  assign rsp_valid = w_fifo_ne;
  assign rsp_rdata = w_fifo_ne ? r_fifo[r_rd_ptr] : '0;
`endif
  assign w_push     = w_exit.valid && !w_bypass;
  assign w_pop_fifo = w_fifo_ne && rsp_ready;
  assign w_rsp_hs   = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_addr  <= '0;
      sram_wmask <= '0;
      sram_din   <= '0;
      r_tag      <= '0;
    end else begin
      r_tag <= {r_tag[SRAM_LAT-1:0], w_new_tag};
      if (w_acc) begin
        sram_csb   <= 1'b0;
        sram_web   <= !req_we;
        sram_addr  <= req_addr[BASE_W-1:0];
        sram_wmask <= req_we ? w_wmask : '0;
        if (req_we) sram_din <= w_din;
      end else begin
        sram_csb   <= 1'b1;
        sram_web   <= 1'b1;
        sram_wmask <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_ext_rdata;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_fifo) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_fcnt <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop_fifo);
      // Credit covers reads in the tag pipe as well as FIFO entries, so the FIFO cannot overflow.
      r_cnt  <= r_cnt + CNT_W'(w_rd_acc) - CNT_W'(w_rsp_hs);
    end
  end

endmodule
